// File: rtl/base_hps_motor_pwm_if.sv
// base_hps_motor_pwm_if: Avalon-MM slave bus bundle for the motor PWM block.
interface base_hps_motor_pwm_if #(parameter int ADDR_W = 4);
  logic [ADDR_W-1:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/base_hps_motor_pwm.sv
// base_hps_motor_pwm: Avalon-MM multi-channel PWM/direction motor driver with prescaler and ramp limiting.
module base_hps_motor_pwm #(
  parameter int CHANNELS = 4,
  parameter int DUTY_W = 9,
  parameter int ADDR_W = 4
) (
  input  logic clk,
  input  logic reset,
  base_hps_motor_pwm_if.slave bus,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] dir_out
);
  localparam int RW = DUTY_W + 10;
  typedef logic signed [DUTY_W:0] duty_t;
  logic enable;
  logic [7:0] step;
  logic [15:0] presc, pcnt;
  logic [DUTY_W-1:0] period, cnt;
  duty_t target [CHANNELS];
  duty_t current [CHANNELS];
  duty_t ramp [CHANNELS];
  logic [DUTY_W:0] cur_abs [CHANNELS];
  duty_t wdat;
  logic signed [RW-1:0] d, mag, s_ext;
  logic wr, wr_ctrl, wr_period, en_next, tick, wrap;
  assign wr = bus.chipselect && !bus.write_n;
  assign wr_ctrl = wr && bus.address == '0;
  assign wr_period = wr && bus.address == ADDR_W'(1);
  assign en_next = wr_ctrl ? bus.writedata[0] : enable;
  assign tick = enable && pcnt >= presc;
  assign wrap = tick && cnt == period;
  assign s_ext = {{(RW-8){1'b0}}, step};
  // the most negative code has no positive twin, so fold it onto -(2^DUTY_W-1)
  assign wdat = bus.writedata[DUTY_W:0] == {1'b1, {DUTY_W{1'b0}}} ? {1'b1, {(DUTY_W-1){1'b0}}, 1'b1} : bus.writedata[DUTY_W:0];
  always_comb begin
    d = '0;
    mag = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      d = target[c] - current[c];
      mag = d < 0 ? -d : d;
      ramp[c] = step == 0 || mag <= s_ext ? target[c] : duty_t'(d < 0 ? current[c] - s_ext : current[c] + s_ext);
      cur_abs[c] = current[c][DUTY_W] ? -current[c] : current[c];
    end
  end
  always_comb begin
    bus.readdata = '0;
    if (bus.address == '0) bus.readdata = {presc, step, 7'd0, enable};
    else if (bus.address == ADDR_W'(1)) bus.readdata = {{(32-DUTY_W){1'b0}}, period};
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.address == ADDR_W'(2 + 2 * c)) bus.readdata = {{(31-DUTY_W){target[c][DUTY_W]}}, target[c]};
      if (bus.address == ADDR_W'(3 + 2 * c)) bus.readdata = {{(31-DUTY_W){current[c][DUTY_W]}}, current[c]};
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable <= 1'b0;
      step <= '0;
      presc <= '0;
      period <= '1;
      pcnt <= '0;
      cnt <= '0;
      pwm_out <= '0;
      dir_out <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        target[c] <= '0;
        current[c] <= '0;
      end
    end else begin
      if (wr_ctrl) {presc, step, enable} <= {bus.writedata[31:16], bus.writedata[15:8], bus.writedata[0]};
      if (wr_period) period <= bus.writedata[DUTY_W-1:0];
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr && bus.address == ADDR_W'(2 + 2 * c)) target[c] <= wdat;
        pwm_out[c] <= enable && ({1'b0, cnt} < cur_abs[c]);
        dir_out[c] <= current[c][DUTY_W];
      end
      // a PERIOD write or any disabled cycle restarts counting and suppresses the ramp
      if (!enable || !en_next || wr_period) begin
        pcnt <= '0;
        cnt <= '0;
        if (!en_next)
          for (int c = 0; c < CHANNELS; c++) current[c] <= '0;
      end else if (tick) begin
        pcnt <= '0;
        cnt <= wrap ? '0 : cnt + 1'b1;
        if (wrap)
          for (int c = 0; c < CHANNELS; c++) current[c] <= ramp[c];
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_base_hps_motor_pwm.sv
// tb_base_hps_motor_pwm: directed test of register map, ramping, prescaler, enable and reset behaviour.
module tb_base_hps_motor_pwm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] pwm, dir;
  int checks = 0;
  int failures = 0;
  int hi;
  base_hps_motor_pwm_if #(.ADDR_W(4)) bus();
  base_hps_motor_pwm #(.CHANNELS(4), .DUTY_W(9), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .pwm_out(pwm), .dir_out(dir)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    bus.address = a;
    #1;
    chk(tag, bus.readdata, exp);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] dat);
    bus.address = a;
    bus.writedata = dat;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask
  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    bus.address = '0;
    bus.writedata = '0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    skip(2);
    reset = 1'b0;
    rd(4'd0, 32'h0, "ctrl_rst");
    rd(4'd1, 32'h1FF, "period_rst");
    for (int a = 2; a < 16; a++) rd(4'(a), 32'h0, $sformatf("reg%0d_rst", a));
    chk("pwm_rst", 32'(pwm), 32'h0);
    chk("dir_rst", 32'(dir), 32'h0);
    skip(1);
    // channel 0: fixed duty 3 of 10, no ramp
    wr(4'd1, 32'd9);
    wr(4'd2, 32'd3);
    wr(4'd0, 32'h1);
    skip(12);
    rd(4'd3, 32'd3, "cur0_steady");
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hi += int'(pwm[0]);
    end
    chk("pwm0_duty", 32'(hi), 32'd3);
    chk("dir0", 32'(dir[0]), 32'h0);
    chk("pwm_idle", 32'(pwm[3:1]), 32'h0);
    // channel 1: ramp to -5 with step 2, then back to +3
    wr(4'd0, 32'h201);
    wr(4'd4, 32'hFFFF_FFFB);
    wr(4'd1, 32'd9);
    skip(10);
    rd(4'd5, 32'hFFFF_FFFE, "cur1_m2");
    skip(1);
    chk("dir1_neg", 32'(dir[1]), 32'h1);
    skip(9);
    rd(4'd5, 32'hFFFF_FFFC, "cur1_m4");
    skip(10);
    rd(4'd5, 32'hFFFF_FFFB, "cur1_m5");
    wr(4'd4, 32'd3);
    skip(9);
    rd(4'd5, 32'hFFFF_FFFD, "cur1_m3");
    skip(10);
    rd(4'd5, 32'hFFFF_FFFF, "cur1_m1");
    skip(1);
    chk("dir1_still_neg", 32'(dir[1]), 32'h1);
    skip(9);
    rd(4'd5, 32'd1, "cur1_p1");
    skip(1);
    chk("dir1_pos", 32'(dir[1]), 32'h0);
    skip(9);
    rd(4'd5, 32'd3, "cur1_p3");
    // channel 2: prescale 3, period 4, duty beyond period
    wr(4'd0, 32'h0003_0001);
    wr(4'd6, 32'd5);
    wr(4'd1, 32'd4);
    skip(19);
    rd(4'd7, 32'd0, "cur2_prewrap");
    skip(1);
    rd(4'd7, 32'd5, "cur2_wrap20");
    hi = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      hi += int'(pwm[2]);
    end
    chk("pwm2_full", 32'(hi), 32'd25);
    skip(14);
    wr(4'd6, 32'd2);
    rd(4'd7, 32'd5, "cur2_coinc_old");
    skip(19);
    rd(4'd7, 32'd5, "cur2_hold");
    skip(1);
    rd(4'd7, 32'd2, "cur2_next_wrap");
    wr(4'd6, 32'd4);
    skip(18);
    wr(4'd1, 32'd4);
    rd(4'd7, 32'd2, "cur2_period_wins");
    skip(19);
    rd(4'd7, 32'd2, "cur2_period_hold");
    skip(1);
    rd(4'd7, 32'd4, "cur2_after_restart");
    // channel 3: ramp, disable mid-ramp, re-enable
    wr(4'd0, 32'h101);
    wr(4'd8, 32'hFFFF_FFF9);
    wr(4'd1, 32'd9);
    skip(30);
    rd(4'd9, 32'hFFFF_FFFD, "cur3_m3");
    skip(1);
    chk("dir3_neg", 32'(dir[3]), 32'h1);
    wr(4'd0, 32'h100);
    rd(4'd9, 32'h0, "cur3_off");
    rd(4'd7, 32'h0, "cur2_off");
    chk("dir3_lag", 32'(dir[3]), 32'h1);
    skip(1);
    chk("pwm_off", 32'(pwm), 32'h0);
    chk("dir_off", 32'(dir), 32'h0);
    rd(4'd8, 32'hFFFF_FFF9, "tgt3_kept");
    rd(4'd2, 32'd3, "tgt0_kept");
    wr(4'd0, 32'h101);
    skip(9);
    rd(4'd9, 32'h0, "cur3_reen_pre");
    skip(1);
    rd(4'd9, 32'hFFFF_FFFF, "cur3_reen_m1");
    // clamp, ignored writes, readback
    wr(4'd2, 32'h200);
    rd(4'd2, 32'hFFFF_FE01, "tgt0_clamp");
    wr(4'd12, 32'h55);
    rd(4'd12, 32'h0, "unmapped_wr");
    rd(4'd0, 32'h101, "ctrl_rb");
    // asynchronous reset while a pwm output is high
    for (int i = 0; i < 40 && pwm == 4'h0; i++) @(negedge clk);
    chk("pwm_seen", 32'(pwm != 4'h0), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("pwm_async", 32'(pwm), 32'h0);
    chk("dir_async", 32'(dir), 32'h0);
    rd(4'd1, 32'h1FF, "period_async");
    skip(1);
    reset = 1'b0;
    skip(2);
    rd(4'd0, 32'h0, "ctrl_after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
